state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/state_sequencer_pkg.sv | 61 ++++++
 rtl/state_sequencer_lmsm_counter.sv | 36 +++
 rtl/state_sequencer.sv | 113 +++++++++++
 tb/tb_state_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/state_sequencer_pkg.sv
// Shared processor package: state IDs, opcodes and condition codes used by the
// sequencer and the control decoder.
`default_nettype none

package state_sequencer_pkg;

  typedef enum logic [5:0] {
    ST_FETCH    = 6'd0,
    ST_ALU_EX   = 6'd1,
    ST_ALU_WB   = 6'd2,
    ST_ADI_EX   = 6'd3,
    ST_ADI_WB   = 6'd4,
    ST_NDU_EX   = 6'd8,
    ST_NDU_WB   = 6'd9,
    ST_LHI_EX   = 6'd11,
    ST_LHI_WB   = 6'd12,
    ST_BEQ_PC   = 6'd13,
    ST_BEQ_WB   = 6'd14,
    ST_SW_ADDR  = 6'd15,
    ST_SW_MEM   = 6'd16,
    ST_LW_MEM   = 6'd18,
    ST_LW_WB    = 6'd19,
    ST_JAL_EX   = 6'd20,
    ST_JAL_WB   = 6'd21,
    ST_PCINC    = 6'd22,
    ST_LW_ADDR  = 6'd24,
    ST_BEQ_CMP  = 6'd28,
    ST_JLR      = 6'd29,
    ST_LM_INIT  = 6'd30,
    ST_LM_CHECK = 6'd31,
    ST_LM_READ  = 6'd32,
    ST_LM_ADV   = 6'd33,
    ST_SM_INIT  = 6'd34,
    ST_SM_CHECK = 6'd35,
    ST_SM_WRITE = 6'd36,
    ST_SM_ADV   = 6'd37
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] COND_Z = 2'b01;

  // Conditional ALU ops are squashed when their selected flag is clear.
  function automatic logic cond_skip(input logic [1:0] cond, input logic c, input logic z);
    return ((cond == COND_C) && !c) || ((cond == COND_Z) && !z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/state_sequencer_lmsm_counter.sv
// LM/SM register-list latch and 3-bit index counter.
`default_nettype none

module lmsm_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] list_in,
  output logic [2:0] idx,
  output logic       bit_set,
  output logic       last
);

  logic [7:0] list_q;
  logic [2:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      list_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      list_q <= list_in;
      cnt_q  <= '0;
    end else if (step && !last) begin
      cnt_q  <= cnt_q + 3'd1;
    end
  end

  assign idx     = cnt_q;
  assign bit_set = list_q[cnt_q];
  assign last    = (cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/state_sequencer.sv
// Multi-cycle instruction sequencer: Moore FSM whose registered state drives the
// control decoder, including the LM/SM register-list loop.
`default_nettype none

module state_sequencer
  import state_sequencer_pkg::*;
#(
  parameter int STATE_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        ir,
  input  logic               mem_ready,
  input  logic               compare,
  input  logic               carry_flag,
  input  logic               zero_flag,
  output logic [STATE_W-1:0] state_id,
  output logic [2:0]         reg_idx,
  output logic               instr_done,
  output logic               illegal_op
);

  state_e     state_q, state_d;
  logic       lm_load, lm_step, lm_bit_set, lm_last;
  logic [3:0] opcode;
  logic       skip;
  logic       ir_unused;

  assign opcode    = ir[15:12];
  assign skip      = cond_skip(ir[1:0], carry_flag, zero_flag);
  assign ir_unused = ^ir[11:8];

  lmsm_counter u_lmsm_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (lm_load),
    .step    (lm_step),
    .list_in (ir[7:0]),
    .idx     (reg_idx),
    .bit_set (lm_bit_set),
    .last    (lm_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = ST_FETCH;
    lm_load    = 1'b0;
    lm_step    = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH:    state_d = mem_ready ? ST_PCINC : ST_FETCH;
      ST_PCINC: begin
        case (opcode)
          OP_ADD:  state_d = skip ? ST_FETCH : ST_ALU_EX;
          OP_NDU:  state_d = skip ? ST_FETCH : ST_NDU_EX;
          OP_ADI:  state_d = ST_ADI_EX;
          OP_LHI:  state_d = ST_LHI_EX;
          OP_LW:   state_d = ST_LW_ADDR;
          OP_SW:   state_d = ST_SW_ADDR;
          OP_BEQ:  state_d = ST_BEQ_CMP;
          OP_JAL:  state_d = ST_JAL_EX;
          OP_JLR:  state_d = ST_JLR;
          OP_LM:   state_d = ST_LM_INIT;
          OP_SM:   state_d = ST_SM_INIT;
          default: illegal_op = 1'b1;
        endcase
      end
      ST_ALU_EX:   state_d = ST_ALU_WB;
      ST_NDU_EX:   state_d = ST_NDU_WB;
      ST_ADI_EX:   state_d = ST_ADI_WB;
      ST_LHI_EX:   state_d = ST_LHI_WB;
      ST_LW_ADDR:  state_d = ST_LW_MEM;
      ST_LW_MEM:   state_d = mem_ready ? ST_LW_WB : ST_LW_MEM;
      ST_SW_ADDR:  state_d = ST_SW_MEM;
      ST_SW_MEM:   state_d = mem_ready ? ST_FETCH : ST_SW_MEM;
      ST_BEQ_CMP:  state_d = compare ? ST_BEQ_PC : ST_FETCH;
      ST_BEQ_PC:   state_d = ST_BEQ_WB;
      ST_JAL_EX:   state_d = ST_JAL_WB;
      ST_LM_INIT: begin
        lm_load = 1'b1;
        state_d = ST_LM_CHECK;
      end
      ST_LM_CHECK: state_d = lm_bit_set ? ST_LM_READ : ST_LM_ADV;
      ST_LM_READ:  state_d = mem_ready ? ST_LM_ADV : ST_LM_READ;
      ST_LM_ADV: begin
        lm_step = !lm_last;
        state_d = lm_last ? ST_FETCH : ST_LM_CHECK;
      end
      ST_SM_INIT: begin
        lm_load = 1'b1;
        state_d = ST_SM_CHECK;
      end
      ST_SM_CHECK: state_d = lm_bit_set ? ST_SM_WRITE : ST_SM_ADV;
      ST_SM_WRITE: state_d = mem_ready ? ST_SM_ADV : ST_SM_WRITE;
      ST_SM_ADV: begin
        lm_step = !lm_last;
        state_d = lm_last ? ST_FETCH : ST_SM_CHECK;
      end
      // Single-cycle tails and unused encodings all land back in FETCH.
      default:     state_d = ST_FETCH;
    endcase
  end

  assign instr_done = (state_d == ST_FETCH) && (state_q != ST_FETCH);
  assign state_id   = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_state_sequencer.sv
// Directed vector bench for state_sequencer.
`default_nettype none

module tb_state_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        mem_ready, compare, carry_flag, zero_flag;
  logic [5:0]  state_id;
  logic [2:0]  reg_idx;
  logic        instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  state_sequencer #(.STATE_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .compare    (compare),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .state_id   (state_id),
    .reg_idx    (reg_idx),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic        mr;
    logic        cmp;
    logic        c;
    logic        z;
    logic [5:0]  st;
    logic        done;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] i, input logic mr, input logic cmp,
                              input logic c, input logic z, input logic [5:0] st,
                              input logic done, input logic ill);
    vec_t v;
    v.ir = i; v.mr = mr; v.cmp = cmp; v.c = c; v.z = z;
    v.st = st; v.done = done; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, then check this cycle's outputs.
  task automatic cyc(input logic [15:0] i, input logic mr, input logic cmp, input logic c,
                     input logic z, input int es, input int ei, input logic ed,
                     input logic eil, input string nm);
    @(negedge clk);
    ir = i; mem_ready = mr; compare = cmp; carry_flag = c; zero_flag = z;
    #1;
    chk({nm, " state"}, 32'(state_id), es);
    if (ei >= 0) chk({nm, " reg_idx"}, 32'(reg_idx), ei);
    chk({nm, " instr_done"}, 32'(instr_done), 32'(ed));
    chk({nm, " illegal_op"}, 32'(illegal_op), 32'(eil));
  endtask

  initial begin
    // ADI
    vecs.push_back(mk(16'h1283, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h1283, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'h1283, 1, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(16'h1283, 1, 0, 0, 0, 4, 1, 0));
    // ADC squashed, then taken
    vecs.push_back(mk(16'h0002, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0002, 1, 0, 0, 0, 22, 1, 0));
    vecs.push_back(mk(16'h0002, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0002, 1, 0, 1, 0, 22, 0, 0));
    vecs.push_back(mk(16'h0002, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(16'h0002, 1, 0, 1, 0, 2, 1, 0));
    // FETCH hold
    vecs.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0));
    // NDZ squashed, then taken
    vecs.push_back(mk(16'h2001, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2001, 1, 0, 1, 0, 22, 1, 0));
    vecs.push_back(mk(16'h2001, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(16'h2001, 1, 0, 0, 1, 22, 0, 0));
    vecs.push_back(mk(16'h2001, 1, 0, 0, 1, 8, 0, 0));
    vecs.push_back(mk(16'h2001, 1, 0, 0, 1, 9, 1, 0));
    // LHI, JAL, JLR
    vecs.push_back(mk(16'h3000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h3000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'h3000, 1, 0, 0, 0, 11, 0, 0));
    vecs.push_back(mk(16'h3000, 1, 0, 0, 0, 12, 1, 0));
    vecs.push_back(mk(16'h8000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h8000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'h8000, 1, 0, 0, 0, 20, 0, 0));
    vecs.push_back(mk(16'h8000, 1, 0, 0, 0, 21, 1, 0));
    vecs.push_back(mk(16'h9000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h9000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'h9000, 1, 0, 0, 0, 29, 1, 0));
    // LW with three wait cycles in 18
    vecs.push_back(mk(16'h4000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h4000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'h4000, 1, 0, 0, 0, 24, 0, 0));
    vecs.push_back(mk(16'h4000, 0, 0, 0, 0, 18, 0, 0));
    vecs.push_back(mk(16'h4000, 0, 0, 0, 0, 18, 0, 0));
    vecs.push_back(mk(16'h4000, 0, 0, 0, 0, 18, 0, 0));
    vecs.push_back(mk(16'h4000, 1, 0, 0, 0, 18, 0, 0));
    vecs.push_back(mk(16'h4000, 0, 0, 0, 0, 19, 1, 0));
    // BEQ not taken, then taken
    vecs.push_back(mk(16'hC000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 0, 0, 0, 28, 1, 0));
    vecs.push_back(mk(16'hC000, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 1, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 1, 0, 0, 28, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 1, 0, 0, 13, 0, 0));
    vecs.push_back(mk(16'hC000, 1, 1, 0, 0, 14, 1, 0));
    // Illegal opcode 1111
    vecs.push_back(mk(16'hF000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hF000, 1, 0, 0, 0, 22, 1, 1));
    vecs.push_back(mk(16'hF000, 0, 0, 0, 0, 0, 0, 0));
    // SW: ir changes and stray mem_ready in 15 must be ignored
    vecs.push_back(mk(16'h5000, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h5000, 1, 0, 0, 0, 22, 0, 0));
    vecs.push_back(mk(16'hF000, 1, 0, 0, 0, 15, 0, 0));
    vecs.push_back(mk(16'hF000, 0, 0, 0, 0, 16, 0, 0));
    vecs.push_back(mk(16'hF000, 1, 0, 0, 0, 16, 1, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0));

    reset = 1'b1; ir = '0; mem_ready = 1'b0; compare = 1'b0;
    carry_flag = 1'b0; zero_flag = 1'b0;
    @(negedge clk); #1;
    chk("reset state", 32'(state_id), 0);
    chk("reset reg_idx", 32'(reg_idx), 0);
    chk("reset instr_done", 32'(instr_done), 0);
    chk("reset illegal_op", 32'(illegal_op), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      cyc(vecs[k].ir, vecs[k].mr, vecs[k].cmp, vecs[k].c, vecs[k].z, int'(vecs[k].st), -1,
          vecs[k].done, vecs[k].ill, $sformatf("vec%0d", k));

    // LM list 0x81; ir is scrambled after INIT to prove the list is latched once
    cyc(16'h6081, 1, 0, 0, 0, 0, -1, 0, 0, "lm fetch");
    cyc(16'h6081, 1, 0, 0, 0, 22, -1, 0, 0, "lm pcinc");
    cyc(16'h6081, 1, 0, 0, 0, 30, -1, 0, 0, "lm init");
    cyc(16'h0000, 1, 0, 0, 0, 31, 0, 0, 0, "lm check0");
    cyc(16'h0000, 0, 0, 0, 0, 32, 0, 0, 0, "lm read0 wait");
    cyc(16'h0000, 1, 0, 0, 0, 32, 0, 0, 0, "lm read0");
    cyc(16'h0000, 1, 0, 0, 0, 33, 0, 0, 0, "lm adv0");
    for (int i = 1; i < 7; i++) begin
      cyc(16'h0000, 1, 0, 0, 0, 31, i, 0, 0, $sformatf("lm check%0d", i));
      cyc(16'h0000, 1, 0, 0, 0, 33, i, 0, 0, $sformatf("lm adv%0d", i));
    end
    cyc(16'h0000, 0, 0, 0, 0, 31, 7, 0, 0, "lm check7");
    cyc(16'h0000, 1, 0, 0, 0, 32, 7, 0, 0, "lm read7");
    cyc(16'h0000, 0, 0, 0, 0, 33, 7, 1, 0, "lm adv7");
    cyc(16'h0000, 0, 0, 0, 0, 0, -1, 0, 0, "lm end");

    // SM with empty list: 1 + 8x2 cycles, never entering 36
    cyc(16'h7000, 1, 0, 0, 0, 0, -1, 0, 0, "sm fetch");
    cyc(16'h7000, 1, 0, 0, 0, 22, -1, 0, 0, "sm pcinc");
    cyc(16'h7000, 1, 0, 0, 0, 34, -1, 0, 0, "sm init");
    for (int i = 0; i < 8; i++) begin
      cyc(16'h7000, 1, 0, 0, 0, 35, i, 0, 0, $sformatf("sm check%0d", i));
      cyc(16'h7000, 1, 0, 0, 0, 37, i, (i == 7), 0, $sformatf("sm adv%0d", i));
    end
    cyc(16'h0000, 0, 0, 0, 0, 0, -1, 0, 0, "sm end");

    // Asynchronous reset inside the LM loop at state 33, cnt 4
    cyc(16'h6000, 1, 0, 0, 0, 0, -1, 0, 0, "rst fetch");
    cyc(16'h6000, 1, 0, 0, 0, 22, -1, 0, 0, "rst pcinc");
    cyc(16'h6000, 1, 0, 0, 0, 30, -1, 0, 0, "rst init");
    for (int i = 0; i < 4; i++) begin
      cyc(16'h6000, 0, 0, 0, 0, 31, i, 0, 0, $sformatf("rst check%0d", i));
      cyc(16'h6000, 0, 0, 0, 0, 33, i, 0, 0, $sformatf("rst adv%0d", i));
    end
    cyc(16'h6000, 0, 0, 0, 0, 31, 4, 0, 0, "rst check4");
    @(negedge clk); #1;
    chk("pre-reset state", 32'(state_id), 33);
    chk("pre-reset reg_idx", 32'(reg_idx), 4);
    reset = 1'b1;
    #1;
    chk("async reset state", 32'(state_id), 0);
    chk("async reset reg_idx", 32'(reg_idx), 0);
    chk("async reset instr_done", 32'(instr_done), 0);
    chk("async reset illegal_op", 32'(illegal_op), 0);
    ir = 16'h1283; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc(16'h1283, 1, 0, 0, 0, 22, -1, 0, 0, "post-reset pcinc");
    cyc(16'h1283, 1, 0, 0, 0, 3, -1, 0, 0, "post-reset adi ex");
    cyc(16'h1283, 0, 0, 0, 0, 4, -1, 1, 0, "post-reset adi wb");
    cyc(16'h0000, 0, 0, 0, 0, 0, -1, 0, 0, "post-reset idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
